// File: rtl/reg_file_2r1w_if.sv
// Write/read port bundle for reg_file_2r1w.
// master drives addresses and write data; slave returns read data.
interface reg_file_2r1w_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
);
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [AW-1:0]    raddr_a;
  logic [WIDTH-1:0] rdata_a;
  logic [AW-1:0]    raddr_b;
  logic [WIDTH-1:0] rdata_b;
  logic             wr_err;

  modport master (
    output we, waddr, wdata,
    output raddr_a, raddr_b,
    input  rdata_a, rdata_b, wr_err
  );

  modport slave (
    input  we, waddr, wdata,
    input  raddr_a, raddr_b,
    output rdata_a, rdata_b, wr_err
  );
endinterface

// File: rtl/reg_file_2r1w.sv
// DEPTH x WIDTH flop register file, 1 write / 2 combinational reads.
// Optional REG_FILE_BYPASS_EN forwards same-cycle write data to reads.
module reg_file_2r1w #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 32,
  parameter bit               ZERO_REG  = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic           clk,
  input  logic           res,
  input  logic           clr,
  reg_file_2r1w_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             wr_err_q;
  logic             wr_err_d;

  logic [DEPTH-1:0] w_sel;
  logic [DEPTH-1:0] w_mask;
  logic             wr_ok;
  logic             wr_oob;

  // One-hot decode; an empty w_sel means waddr is past DEPTH
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_sel[i] = (bus.waddr == AW'(i));
    end
    w_mask = w_sel;
    if (ZERO_REG) begin
      w_mask[0] = 1'b0;
    end
    wr_ok  = bus.we & ~clr & (|w_sel);
    wr_oob = bus.we & ~clr & ~(|w_sel);
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    wr_err_d = 1'b0;
    unique case (1'b1)
      clr: begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_d[i] = RESET_VAL;
        end
      end
      wr_oob: wr_err_d = 1'b1;
      wr_ok: begin
        for (int i = 0; i < DEPTH; i++) begin
          if (w_mask[i]) begin
            mem_d[i] = bus.wdata;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RESET_VAL;
      end
      wr_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_err_q <= wr_err_d;
    end
  end

  function automatic logic [WIDTH-1:0] rd(
    input logic [AW-1:0] a
  );
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (a == AW'(i) && !(ZERO_REG && i == 0)) begin
        r = mem_q[i];
      end
    end
`ifdef REG_FILE_BYPASS_EN
    // w_mask is empty for a masked word 0, so it never forwards
    if (wr_ok && (|w_mask) && a == bus.waddr) begin
      r = bus.wdata;
    end
`endif
    return r;
  endfunction

  always_comb begin
    bus.rdata_a = rd(bus.raddr_a);
    bus.rdata_b = rd(bus.raddr_b);
  end

  assign bus.wr_err = wr_err_q;
endmodule
